// File: rtl/icap_reboot.sv
`default_nettype none
// ============================================================================
// Module      : icap_reboot
// Description : Issues an IPROG reboot command stream through the ICAP,
//               targeting one of several flash bitstream slots.
// Revision    : 1.0 - initial release
// ============================================================================
module icap_reboot #(
    parameter int          NSLOTS      = 2,
    parameter logic [23:0] BASE_ADDR   = 24'h050000,
    parameter logic [23:0] SLOT_STRIDE = 24'h320000,
    parameter logic [23:0] GOLDEN_ADDR = 24'h050000,
    parameter logic [7:0]  READ_OPCODE = 8'h00,
    parameter int          DELAY_W     = 20,
    parameter int          AUTO_START  = 1,
    parameter int          AUTO_SLOT   = 1
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        start,
    input  logic [2:0]  slot,
    input  logic        rescue,
    output logic        busy,
    output logic        done,
    output logic        icap_ce_n,
    output logic        icap_write_n,
    output logic [15:0] icap_d,
    input  logic        icap_busy
);

    localparam logic [1:0]         c_IDLE     = 2'd0;
    localparam logic [1:0]         c_DELAY    = 2'd1;
    localparam logic [1:0]         c_SEND     = 2'd2;
    localparam logic [1:0]         c_DONE     = 2'd3;
    localparam logic [3:0]         c_LAST_IDX = 4'd13;
    localparam logic [3:0]         c_NSLOTS   = 4'(NSLOTS);
    localparam logic [2:0]         c_AUTO_SLT = 3'(AUTO_SLOT);
    localparam logic               c_AUTO_EN  = (AUTO_START != 0);
    localparam logic [DELAY_W-1:0] c_CNT_ONE  = DELAY_W'(1);

    logic [1:0]         r_state;
    logic [3:0]         r_idx;
    logic [DELAY_W-1:0] r_cnt;
    logic [23:0]        r_addr;
    logic               r_auto;
    logic               r_ce_n;
    logic [15:0]        r_d;

    logic               w_req;
    logic [2:0]         w_slot_sel;
    logic [2:0]         w_eff_slot;
    logic [23:0]        w_offset;
    logic [23:0]        w_target;
    logic [DELAY_W-1:0] w_cnt_next;
    logic [15:0]        w_word;
    logic [15:0]        w_word_rev;

    // The pending auto request is consumed by the first IDLE cycle after reset.
    assign w_req      = start | r_auto;
    assign w_slot_sel = start ? slot : c_AUTO_SLT;
    assign w_eff_slot = (rescue || ({1'b0, w_slot_sel} >= c_NSLOTS)) ? 3'd0 : w_slot_sel;
    assign w_offset   = {21'd0, w_eff_slot} * SLOT_STRIDE;
    assign w_target   = BASE_ADDR + w_offset;
    assign w_cnt_next = r_cnt + c_CNT_ONE;

    always_comb begin
        w_word = 16'hFFFF;
        case (r_idx)
            4'd0:    w_word = 16'hFFFF;
            4'd1:    w_word = 16'hAA99;
            4'd2:    w_word = 16'h5566;
            4'd3:    w_word = 16'h3261;
            4'd4:    w_word = r_addr[15:0];
            4'd5:    w_word = 16'h3281;
            4'd6:    w_word = {READ_OPCODE, r_addr[23:16]};
            4'd7:    w_word = 16'h3301;
            4'd8:    w_word = GOLDEN_ADDR[15:0];
            4'd9:    w_word = 16'h3321;
            4'd10:   w_word = {READ_OPCODE, GOLDEN_ADDR[23:16]};
            4'd11:   w_word = 16'h30A1;
            4'd12:   w_word = 16'h000E;
            4'd13:   w_word = 16'h2000;
            default: w_word = 16'hFFFF;
        endcase
    end

    // ICAP expects each byte bit-swapped relative to the bitstream word.
    always_comb begin
        w_word_rev = 16'h0000;
        for (int i = 0; i < 8; i++) begin
            w_word_rev[7-i]  = w_word[i];
            w_word_rev[15-i] = w_word[8+i];
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_state <= c_IDLE;
            r_idx   <= 4'd0;
            r_cnt   <= '0;
            r_addr  <= 24'd0;
            r_auto  <= c_AUTO_EN;
            r_ce_n  <= 1'b1;
            r_d     <= 16'hFFFF;
        end else begin
            r_ce_n <= 1'b1;
            r_d    <= 16'hFFFF;
            case (r_state)
                c_IDLE: begin
                    if (w_req) begin
                        r_addr  <= w_target;
                        r_cnt   <= '0;
                        r_auto  <= 1'b0;
                        r_state <= c_DELAY;
                    end
                end
                c_DELAY: begin
                    r_cnt <= w_cnt_next;
                    if (w_cnt_next[DELAY_W-1]) begin
                        r_idx   <= 4'd0;
                        r_state <= c_SEND;
                    end
                end
                c_SEND: begin
                    // A stalled word is re-presented because the index holds.
                    r_ce_n <= 1'b0;
                    r_d    <= w_word_rev;
                    if (!icap_busy) begin
                        if (r_idx == c_LAST_IDX) begin
                            r_state <= c_DONE;
                        end else begin
                            r_idx <= r_idx + 4'd1;
                        end
                    end
                end
                c_DONE: begin
                    r_state <= c_DONE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign busy         = (r_state == c_DELAY) || (r_state == c_SEND);
    assign done         = (r_state == c_DONE);
    assign icap_ce_n    = r_ce_n;
    assign icap_write_n = r_ce_n;
    assign icap_d       = r_d;

endmodule
`default_nettype wire

// File: tb/tb_icap_reboot.sv
`default_nettype none
// ============================================================================
// Module      : tb_icap_reboot
// Description : Scoreboard bench for icap_reboot (auto-start and manual DUTs).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_icap_reboot;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        a_rst = 1'b1, a_start = 1'b0, a_rescue = 1'b0, a_ibusy = 1'b0;
    logic [2:0]  a_slot = 3'd0;
    logic        a_busy, a_done, a_ce_n, a_wn;
    logic [15:0] a_d;

    logic        b_rst = 1'b1, b_start = 1'b0, b_rescue = 1'b0, b_ibusy = 1'b0;
    logic [2:0]  b_slot = 3'd0;
    logic        b_busy, b_done, b_ce_n, b_wn;
    logic [15:0] b_d;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          a_ce_cnt = 0;
    int          b_ce_cnt = 0;
    logic [15:0] q_a[$];
    logic [15:0] q_b[$];

    icap_reboot #(.DELAY_W(4)) u_dut_a (
        .sys_clk(clk), .sys_rst(a_rst), .start(a_start), .slot(a_slot),
        .rescue(a_rescue), .busy(a_busy), .done(a_done), .icap_ce_n(a_ce_n),
        .icap_write_n(a_wn), .icap_d(a_d), .icap_busy(a_ibusy)
    );

    icap_reboot #(.DELAY_W(4), .AUTO_START(0), .NSLOTS(4)) u_dut_b (
        .sys_clk(clk), .sys_rst(b_rst), .start(b_start), .slot(b_slot),
        .rescue(b_rescue), .busy(b_busy), .done(b_done), .icap_ce_n(b_ce_n),
        .icap_write_n(b_wn), .icap_d(b_d), .icap_busy(b_ibusy)
    );

    function automatic logic [15:0] brev(input logic [15:0] w);
        logic [15:0] r;
        r = 16'h0000;
        for (int i = 0; i < 8; i++) begin
            r[7-i]  = w[i];
            r[15-i] = w[8+i];
        end
        return r;
    endfunction

    function automatic logic [15:0] word_at(input int i, input logic [23:0] addr);
        case (i)
            0:       return 16'hFFFF;
            1:       return 16'hAA99;
            2:       return 16'h5566;
            3:       return 16'h3261;
            4:       return addr[15:0];
            5:       return 16'h3281;
            6:       return {8'h00, addr[23:16]};
            7:       return 16'h3301;
            8:       return 16'h0000;
            9:       return 16'h3321;
            10:      return 16'h0005;
            11:      return 16'h30A1;
            12:      return 16'h000E;
            default: return 16'h2000;
        endcase
    endfunction

    task automatic push_a(input logic [23:0] addr);
        for (int i = 0; i < 14; i++) q_a.push_back(brev(word_at(i, addr)));
    endtask

    task automatic push_b(input logic [23:0] addr, input int rep8);
        for (int i = 0; i < 14; i++) begin
            if (i == 8) begin
                for (int k = 0; k < rep8; k++) q_b.push_back(brev(word_at(i, addr)));
            end else begin
                q_b.push_back(brev(word_at(i, addr)));
            end
        end
    endtask

    // Every CE-low sample must be the next expected word.
    always @(negedge clk) begin
        logic [15:0] e;
        if (a_ce_n === 1'b0) begin
            a_ce_cnt++;
            n_checks++;
            if (a_wn !== a_ce_n) begin
                n_fail++; $display("FAIL a_write_n: got %b expected %b", a_wn, a_ce_n);
            end
            n_checks++;
            if (q_a.size() == 0) begin
                n_fail++; $display("FAIL a_word: got %h expected none (unexpected word)", a_d);
            end else begin
                e = q_a.pop_front();
                if (a_d !== e) begin
                    n_fail++; $display("FAIL a_word: got %h expected %h", a_d, e);
                end
            end
        end
        if (b_ce_n === 1'b0) begin
            b_ce_cnt++;
            n_checks++;
            if (b_wn !== b_ce_n) begin
                n_fail++; $display("FAIL b_write_n: got %b expected %b", b_wn, b_ce_n);
            end
            n_checks++;
            if (q_b.size() == 0) begin
                n_fail++; $display("FAIL b_word: got %h expected none (unexpected word)", b_d);
            end else begin
                e = q_b.pop_front();
                if (b_d !== e) begin
                    n_fail++; $display("FAIL b_word: got %h expected %h", b_d, e);
                end
            end
        end
    end

    task automatic start_b(input logic [2:0] s, input logic r);
        @(negedge clk); b_rst = 1'b1;
        @(negedge clk); b_rst = 1'b0;
        b_ce_cnt = 0;
        b_slot = s; b_rescue = r; b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0; b_slot = 3'd2; b_rescue = ~r;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        #1;
        n_checks++; if (a_ce_n !== 1'b1) begin n_fail++; $display("FAIL rst_a_ce_n: got %b expected 1", a_ce_n); end
        n_checks++; if (a_wn !== 1'b1) begin n_fail++; $display("FAIL rst_a_write_n: got %b expected 1", a_wn); end
        n_checks++; if (a_d !== 16'hFFFF) begin n_fail++; $display("FAIL rst_a_d: got %h expected FFFF", a_d); end
        n_checks++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL rst_a_busy: got %b expected 0", a_busy); end
        n_checks++; if (a_done !== 1'b0) begin n_fail++; $display("FAIL rst_a_done: got %b expected 0", a_done); end
        n_checks++; if (b_ce_n !== 1'b1) begin n_fail++; $display("FAIL rst_b_ce_n: got %b expected 1", b_ce_n); end
        n_checks++; if (b_d !== 16'hFFFF) begin n_fail++; $display("FAIL rst_b_d: got %h expected FFFF", b_d); end
    endtask

    // Auto reboot to slot 1 (370000); a start pulse mid-stream must be ignored.
    task automatic test_auto_start();
        int dly;
        int t;
        push_a(24'h370000);
        a_ce_cnt = 0;
        @(negedge clk); a_rst = 1'b0;
        dly = 0;
        for (t = 0; t < 100; t++) begin
            @(negedge clk); #1;
            if (a_ce_n === 1'b0) break;
            if (a_busy === 1'b1) dly++;
        end
        n_checks++; if (dly != 9) begin n_fail++; $display("FAIL auto_delay: got %0d expected 9", dly); end
        for (t = 0; t < 100; t++) begin
            @(negedge clk); #1;
            if (a_ce_cnt == 5) begin a_start = 1'b1; a_slot = 3'd0; end
            else a_start = 1'b0;
            if (a_done === 1'b1 && a_ce_n === 1'b1) break;
        end
        a_start = 1'b0;
        n_checks++; if (t >= 100) begin n_fail++; $display("FAIL auto_timeout: got %0d cycles expected <100", t); end
        n_checks++; if (a_ce_cnt != 14) begin n_fail++; $display("FAIL auto_ce_count: got %0d expected 14", a_ce_cnt); end
        n_checks++; if (q_a.size() != 0) begin n_fail++; $display("FAIL auto_leftover: got %0d expected 0", q_a.size()); end
        n_checks++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL auto_busy_end: got %b expected 0", a_busy); end
        n_checks++; if (a_d !== 16'hFFFF) begin n_fail++; $display("FAIL auto_d_end: got %h expected FFFF", a_d); end
        // DONE is sticky: a new request must not restart the stream.
        @(negedge clk); a_start = 1'b1; a_slot = 3'd1;
        @(negedge clk); a_start = 1'b0;
        repeat (12) @(negedge clk);
        #1;
        n_checks++; if (a_ce_cnt != 14) begin n_fail++; $display("FAIL done_ignore_start: got %0d expected 14", a_ce_cnt); end
        n_checks++; if (a_done !== 1'b1 || a_busy !== 1'b0) begin
            n_fail++; $display("FAIL done_hold: got done=%b busy=%b expected done=1 busy=0", a_done, a_busy);
        end
    endtask

    task automatic test_reset_mid();
        int t;
        int dly;
        @(negedge clk); a_rst = 1'b1;
        push_a(24'h370000);
        a_ce_cnt = 0;
        @(negedge clk); a_rst = 1'b0;
        for (t = 0; t < 100; t++) begin
            @(negedge clk); #1;
            if (a_ce_cnt == 11) break;
        end
        a_rst = 1'b1;
        #1;
        n_checks++; if (a_ce_n !== 1'b1) begin n_fail++; $display("FAIL mid_rst_ce_n: got %b expected 1", a_ce_n); end
        n_checks++; if (a_d !== 16'hFFFF) begin n_fail++; $display("FAIL mid_rst_d: got %h expected FFFF", a_d); end
        n_checks++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL mid_rst_busy: got %b expected 0", a_busy); end
        n_checks++; if (q_a.size() != 3) begin n_fail++; $display("FAIL mid_rst_position: got %0d words left expected 3", q_a.size()); end
        q_a.delete();
        push_a(24'h370000);
        a_ce_cnt = 0;
        @(negedge clk); a_rst = 1'b0;
        dly = 0;
        for (t = 0; t < 100; t++) begin
            @(negedge clk); #1;
            if (a_ce_n === 1'b0) break;
            if (a_busy === 1'b1) dly++;
        end
        n_checks++; if (dly != 9) begin n_fail++; $display("FAIL restart_delay: got %0d expected 9", dly); end
        for (t = 0; t < 100; t++) begin
            @(negedge clk); #1;
            if (a_done === 1'b1 && a_ce_n === 1'b1) break;
        end
        n_checks++; if (a_ce_cnt != 14) begin n_fail++; $display("FAIL restart_ce_count: got %0d expected 14", a_ce_cnt); end
        n_checks++; if (q_a.size() != 0) begin n_fail++; $display("FAIL restart_leftover: got %0d expected 0", q_a.size()); end
    endtask

    // Slot 1 with rescue high must boot slot 0 (050000).
    task automatic test_rescue();
        int t;
        push_b(24'h050000, 1);
        start_b(3'd1, 1'b1);
        #1;
        n_checks++; if (b_busy !== 1'b1) begin n_fail++; $display("FAIL rescue_busy: got %b expected 1", b_busy); end
        for (t = 0; t < 200; t++) begin
            @(negedge clk); #1;
            if (b_done === 1'b1 && b_ce_n === 1'b1) break;
        end
        n_checks++; if (b_ce_cnt != 14) begin n_fail++; $display("FAIL rescue_ce_count: got %0d expected 14", b_ce_cnt); end
        n_checks++; if (q_b.size() != 0) begin n_fail++; $display("FAIL rescue_leftover: got %0d expected 0", q_b.size()); end
    endtask

    // Slot 3 (9B0000) with a three-cycle ICAP stall on word 8.
    task automatic test_slot3_stall();
        int t;
        push_b(24'h9B0000, 4);
        start_b(3'd3, 1'b0);
        for (t = 0; t < 200; t++) begin
            @(negedge clk); #1;
            b_ibusy = (b_ce_cnt >= 8 && b_ce_cnt <= 10);
            if (b_done === 1'b1 && b_ce_n === 1'b1) break;
        end
        b_ibusy = 1'b0;
        n_checks++; if (b_ce_cnt != 17) begin n_fail++; $display("FAIL stall_ce_count: got %0d expected 17", b_ce_cnt); end
        n_checks++; if (q_b.size() != 0) begin n_fail++; $display("FAIL stall_leftover: got %0d expected 0", q_b.size()); end
    endtask

    task automatic test_slot_oob();
        int t;
        push_b(24'h050000, 1);
        start_b(3'd5, 1'b0);
        for (t = 0; t < 200; t++) begin
            @(negedge clk); #1;
            if (b_done === 1'b1 && b_ce_n === 1'b1) break;
        end
        n_checks++; if (t >= 200) begin n_fail++; $display("FAIL oob_timeout: got %0d cycles expected <200", t); end
        n_checks++; if (b_ce_cnt != 14) begin n_fail++; $display("FAIL oob_ce_count: got %0d expected 14", b_ce_cnt); end
        n_checks++; if (q_b.size() != 0) begin n_fail++; $display("FAIL oob_leftover: got %0d expected 0", q_b.size()); end
    endtask

    initial begin
        test_reset();
        test_auto_start();
        test_reset_mid();
        b_rst = 1'b0;
        test_rescue();
        test_slot3_stall();
        test_slot_oob();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
